palu_issue: RTL and testbench
=============================

PALU_ISSUE -- requirements
Module: palu_issue

Interface
REQ-001 SHALL have parameter HZ_STALL, default 1, meaning bubble cycles inserted per detected hazard (legal 1..3).
REQ-002 SHALL have port clock  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port req0  input  1  requester 0 holds an instruction.
REQ-005 SHALL have port instr0  input  12  requester 0 instruction {opcode[11:9], src1[8:6], src2[5:3], dest[2:0]}.
REQ-006 SHALL have port ack0  output  1  requester 0 instruction issued this cycle.
REQ-007 SHALL have port req1  input  1  requester 1 holds an instruction.
REQ-008 SHALL have port instr1  input  12  requester 1 instruction, same packing as instr0.
REQ-009 SHALL have port ack1  output  1  requester 1 instruction issued this cycle.
REQ-010 SHALL have port stall  output  1  bubble to the ALU pipeline; 1 = no instruction this cycle.
REQ-011 SHALL have port opcode  output  3  issued opcode.
REQ-012 SHALL have port src1  output  3  issued source 1 register index.
REQ-013 SHALL have port src2  output  3  issued source 2 register index.
REQ-014 SHALL have port dest  output  3  issued destination register index.
REQ-015 SHALL have port busy  output  1  high in HAZ state or while any unmasked req is pending.

Function
REQ-016 SHALL register all outputs; each edge decides the next cycle's output.
REQ-017 SHALL hold requester handshake: reqN and instrN stable until ackN seen high at an edge; ackN is a one-cycle pulse.
REQ-018 SHALL mask requester N from arbitration at an edge where ackN is currently 1.
REQ-019 SHALL implement states IDLE (no candidate), ISSUE (candidate issued), HAZ (bubble countdown).
REQ-020 SHALL select a candidate among unmasked requests per arbitration policy (REQ-034/035).
REQ-021 SHALL define operand use by opcode: 0,1 use no source; 2,3,4 use src1 and src2; 5,6,7 use src1 only.
REQ-022 SHALL flag a hazard when a used source of the candidate equals dest of the instruction on the outputs with stall=0 in the current cycle.
REQ-023 SHALL, with no hazard, drive candidate fields, stall=0, its ack=1 next cycle; state ISSUE.
REQ-024 SHALL, on hazard, drive stall=1, no ack, load bubble counter with HZ_STALL, enter HAZ, lock the grant to that candidate.
REQ-025 SHALL, in HAZ, decrement counter each edge with stall=1; at counter reaching 1, issue the locked candidate next cycle without rechecking (previous instruction has drained).
REQ-026 SHALL, with no unmasked request, drive stall=1, acks 0, state IDLE; opcode/src/dest hold last values.
REQ-027 SHALL issue at most one instruction per cycle; ack0 and ack1 never both 1.
REQ-028 SHALL, back-to-back independent requests, sustain one issue per cycle (stall=0 continuous).
REQ-029 SHALL ignore a locked requester dropping req in HAZ (protocol violation); instruction still issues from its latched copy.

Reset
REQ-030 SHALL on reset drive stall=1, ack0=ack1=0, opcode=src1=src2=dest=0, busy=0.
REQ-031 SHALL on reset clear state to IDLE, bubble counter 0, locked grant cleared, round-robin pointer to requester 0.
REQ-032 SHALL on reset mid-HAZ discard the locked candidate without ack; requester re-presents it.
REQ-033 SHALL treat reset as overriding all other inputs in that cycle.

Configuration
REQ-034 SHALL, with PALU_ISS_RR_EN defined, arbitrate round-robin: pointer moves to the other requester after each ack.
REQ-035 SHALL, without PALU_ISS_RR_EN, give requester 0 fixed priority over requester 1.

Verification
REQ-036 SHALL test: req0 instr {2,1,2,3}, then {2,4,5,6} -> acks on consecutive cycles, stall=0 both cycles.
REQ-037 SHALL test: {2,1,2,3} then {3,3,0,4}, HZ_STALL=1 -> one stall=1 cycle, then second issues.
REQ-038 SHALL test: {1,0,0,5} then opcode 0 with src1=5 -> no hazard, no bubble.
REQ-039 SHALL test: req0 and req1 held high, RR_EN defined -> acks alternate 0,1,0,1; undefined -> ack0 only until req0 drops.
REQ-040 SHALL test: HZ_STALL=3 hazard, reset asserted in second bubble -> stall=1, no ack, IDLE next cycle.

Source files
------------

// File: rtl/palu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : palu_issue_if
// Description : Requester handshake and issue bus between two instruction
//               requesters, the issue stage and the ALU pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface palu_issue_if;
    logic        req0;
    logic [11:0] instr0;
    logic        ack0;
    logic        req1;
    logic [11:0] instr1;
    logic        ack1;
    logic        stall;
    logic [2:0]  opcode;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [2:0]  dest;
    logic        busy;

    modport master (
        output req0, instr0, req1, instr1,
        input  ack0, ack1, stall, opcode, src1, src2, dest, busy
    );

    modport slave (
        input  req0, instr0, req1, instr1,
        output ack0, ack1, stall, opcode, src1, src2, dest, busy
    );
endinterface
`default_nettype wire

// File: rtl/palu_issue.sv
`default_nettype none
// ============================================================================
// Module      : palu_issue
// Description : Two-requester ALU issue stage with read-after-write hazard
//               bubbles. Define PALU_ISS_RR_EN for round-robin arbitration;
//               otherwise requester 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module palu_issue #(
    parameter int HZ_STALL = 1
) (
    input  wire logic   clock,
    input  wire logic   reset,
    palu_issue_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HAZ   = 2'd2
    } state_t;

    localparam logic [1:0] c_hz_load = 2'(HZ_STALL);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_lock_who;
    logic [11:0] r_lock_ins;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_stall;
    logic [2:0]  r_opcode;
    logic [2:0]  r_src1;
    logic [2:0]  r_src2;
    logic [2:0]  r_dest;
    logic        r_busy;
`ifdef PALU_ISS_RR_EN
    logic        r_ptr;
`endif

    logic        w_req0;
    logic        w_req1;
    logic        w_pick1;
    logic        w_cand_vld;
    logic [11:0] w_cand;
    logic [2:0]  w_cand_op;
    logic        w_use1;
    logic        w_use2;
    logic        w_hazard;
    logic        w_issue;
    logic        w_iss_who;
    logic [11:0] w_iss_ins;
    logic        w_enter_haz;
    logic        w_stay_haz;
    logic        w_busy_nxt;

    // A requester whose ack is on the bus still shows the consumed instruction.
    assign w_req0     = bus.req0 & ~r_ack0;
    assign w_req1     = bus.req1 & ~r_ack1;
    assign w_cand_vld = w_req0 | w_req1;

`ifdef PALU_ISS_RR_EN
    assign w_pick1 = w_req1 & (~w_req0 | r_ptr);
`else
    assign w_pick1 = w_req1 & ~w_req0;
`endif

    always_comb begin
        w_cand    = w_pick1 ? bus.instr1 : bus.instr0;
        w_cand_op = w_cand[11:9];
        w_use1    = (w_cand_op >= 3'd2);
        w_use2    = (w_cand_op >= 3'd2) && (w_cand_op <= 3'd4);
        // Only an instruction actually in flight (stall low) can produce a hazard.
        w_hazard  = ~r_stall && ((w_use1 && (w_cand[8:6] == r_dest)) ||
                                 (w_use2 && (w_cand[5:3] == r_dest)));

        w_issue     = 1'b0;
        w_iss_who   = w_pick1;
        w_iss_ins   = w_cand;
        w_enter_haz = 1'b0;
        w_stay_haz  = 1'b0;
        if (r_state == ST_HAZ) begin
            if (r_cnt == 2'd1) begin
                w_issue   = 1'b1;
                w_iss_who = r_lock_who;
                w_iss_ins = r_lock_ins;
            end else begin
                w_stay_haz = 1'b1;
            end
        end else if (w_cand_vld) begin
            if (w_hazard) begin
                w_enter_haz = 1'b1;
            end else begin
                w_issue = 1'b1;
            end
        end

        w_busy_nxt = w_stay_haz | w_enter_haz |
                     (w_req0 & ~(w_issue & ~w_iss_who)) |
                     (w_req1 & ~(w_issue &  w_iss_who));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 2'd0;
            r_lock_who <= 1'b0;
            r_lock_ins <= 12'd0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_stall    <= 1'b1;
            r_opcode   <= 3'd0;
            r_src1     <= 3'd0;
            r_src2     <= 3'd0;
            r_dest     <= 3'd0;
            r_busy     <= 1'b0;
`ifdef PALU_ISS_RR_EN
            r_ptr      <= 1'b0;
`endif
        end else begin
            r_ack0  <= w_issue & ~w_iss_who;
            r_ack1  <= w_issue &  w_iss_who;
            r_stall <= ~w_issue;
            r_busy  <= w_busy_nxt;
            if (w_issue) begin
                {r_opcode, r_src1, r_src2, r_dest} <= w_iss_ins;
                r_state <= ST_ISSUE;
                r_cnt   <= 2'd0;
`ifdef PALU_ISS_RR_EN
                r_ptr   <= ~w_iss_who;
`endif
            end else if (w_enter_haz) begin
                // Latched copy lets the issue proceed even if the requester misbehaves.
                r_state    <= ST_HAZ;
                r_cnt      <= c_hz_load;
                r_lock_who <= w_pick1;
                r_lock_ins <= w_cand;
            end else if (w_stay_haz) begin
                r_cnt <= r_cnt - 2'd1;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign bus.ack0   = r_ack0;
    assign bus.ack1   = r_ack1;
    assign bus.stall  = r_stall;
    assign bus.opcode = r_opcode;
    assign bus.src1   = r_src1;
    assign bus.src2   = r_src2;
    assign bus.dest   = r_dest;
    assign bus.busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_palu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_palu_issue
// Description : Scoreboard bench for palu_issue (HZ_STALL=1 and HZ_STALL=3).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_palu_issue;

    typedef struct packed {
        logic        who;
        logic [11:0] ins;
    } exp_t;

    logic clock = 1'b0;
    logic rst_a;
    logic rst_b;

    palu_issue_if ia ();
    palu_issue_if ib ();

    palu_issue #(.HZ_STALL(1)) u_dut_a (.clock(clock), .reset(rst_a), .bus(ia));
    palu_issue #(.HZ_STALL(3)) u_dut_b (.clock(clock), .reset(rst_b), .bus(ib));

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb_a[$];
    exp_t        sb_b[$];
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    exp_t        mon_a;
    exp_t        mon_b;

    function automatic logic [11:0] mk(input int op, input int s1, input int s2, input int d);
        return {3'(op), 3'(s1), 3'(s2), 3'(d)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    endtask

    task automatic push_a(input logic who, input logic [11:0] ins);
        exp_t e;
        e.who = who;
        e.ins = ins;
        sb_a.push_back(e);
    endtask

    task automatic push_b(input logic who, input logic [11:0] ins);
        exp_t e;
        e.who = who;
        e.ins = ins;
        sb_b.push_back(e);
    endtask

    // Issue monitors: every ack pops the next expected issue.
    always @(negedge clock) begin
        if (ia.ack0 || ia.ack1) begin
            chk("a_single_ack", 32'(ia.ack0 & ia.ack1), 32'd0);
            chk("a_sb_nonempty", 32'(sb_a.size() != 0), 32'd1);
            if (sb_a.size() != 0) begin
                mon_a = sb_a.pop_front();
                chk("a_who", 32'(ia.ack1), 32'(mon_a.who));
                chk("a_fields", 32'({ia.opcode, ia.src1, ia.src2, ia.dest}), 32'(mon_a.ins));
                chk("a_issue_stall", 32'(ia.stall), 32'd0);
            end
        end
    end

    always @(negedge clock) begin
        if (ib.ack0 || ib.ack1) begin
            chk("b_single_ack", 32'(ib.ack0 & ib.ack1), 32'd0);
            chk("b_sb_nonempty", 32'(sb_b.size() != 0), 32'd1);
            if (sb_b.size() != 0) begin
                mon_b = sb_b.pop_front();
                chk("b_who", 32'(ib.ack1), 32'(mon_b.who));
                chk("b_fields", 32'({ib.opcode, ib.src1, ib.src2, ib.dest}), 32'(mon_b.ins));
                chk("b_issue_stall", 32'(ib.stall), 32'd0);
            end
        end
    end

    // Requester models for DUT A: hold until ack is seen at an edge, then advance.
    initial begin : drv0
        ia.req0   = 1'b0;
        ia.instr0 = '0;
        forever begin
            @(negedge clock);
            if (ia.ack0 && q0.size() > 0) begin
                q0.delete(0);
                @(posedge clock);
                #1;
            end
            if (q0.size() > 0) begin
                ia.req0   = 1'b1;
                ia.instr0 = q0[0];
            end else begin
                ia.req0   = 1'b0;
                ia.instr0 = '0;
            end
        end
    end

    initial begin : drv1
        ia.req1   = 1'b0;
        ia.instr1 = '0;
        forever begin
            @(negedge clock);
            if (ia.ack1 && q1.size() > 0) begin
                q1.delete(0);
                @(posedge clock);
                #1;
            end
            if (q1.size() > 0) begin
                ia.req1   = 1'b1;
                ia.instr1 = q1[0];
            end else begin
                ia.req1   = 1'b0;
                ia.instr1 = '0;
            end
        end
    end

    // Checks the stall value of each cycle from the first issue onward, then drain.
    task automatic run_a(input string nm, input int n, input logic [7:0] pat);
        int k;
        int guard;
        k     = 0;
        guard = 0;
        while (k < n && guard < 40) begin
            @(negedge clock);
            guard++;
            if (k > 0 || ia.ack0 || ia.ack1) begin
                chk({nm, "_stall"}, 32'(ia.stall), 32'(pat[k]));
                k++;
            end
        end
        chk({nm, "_done"}, 32'(k), 32'(n));
        repeat (3) @(negedge clock);
        chk({nm, "_drained"}, 32'(sb_a.size()), 32'd0);
        chk({nm, "_idle_stall"}, 32'(ia.stall), 32'd1);
        chk({nm, "_idle_busy"}, 32'(ia.busy), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        ib.req0   = 1'b0;
        ib.instr0 = '0;
        ib.req1   = 1'b0;
        ib.instr1 = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_stall", 32'(ia.stall), 32'd1);
        chk("rst_acks", 32'({ia.ack1, ia.ack0}), 32'd0);
        chk("rst_fields", 32'({ia.opcode, ia.src1, ia.src2, ia.dest}), 32'd0);
        chk("rst_busy", 32'(ia.busy), 32'd0);
        chk("rst_b_stall", 32'(ib.stall), 32'd1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Independent pair: back-to-back issue.
        push_a(1'b0, mk(2, 1, 2, 3));
        push_a(1'b1, mk(2, 4, 5, 6));
        q0.push_back(mk(2, 1, 2, 3));
        q1.push_back(mk(2, 4, 5, 6));
        run_a("t_indep", 2, 8'b0000_0000);

        // RAW on src1: one bubble.
        push_a(1'b0, mk(2, 1, 2, 3));
        push_a(1'b1, mk(3, 3, 0, 4));
        q0.push_back(mk(2, 1, 2, 3));
        q1.push_back(mk(3, 3, 0, 4));
        run_a("t_raw", 3, 8'b0000_0010);

        // Opcode 0 reads nothing, so matching src1 is harmless.
        push_a(1'b0, mk(1, 0, 0, 5));
        push_a(1'b1, mk(0, 5, 0, 0));
        q0.push_back(mk(1, 0, 0, 5));
        q1.push_back(mk(0, 5, 0, 0));
        run_a("t_nosrc", 2, 8'b0000_0000);

        // Both held: masking forces alternation; opcode 7 ignores src2.
        push_a(1'b0, mk(2, 0, 1, 7));
        push_a(1'b1, mk(3, 0, 1, 6));
        push_a(1'b0, mk(4, 2, 3, 5));
        push_a(1'b1, mk(6, 4, 0, 7));
        push_a(1'b0, mk(7, 1, 7, 2));
        push_a(1'b1, mk(0, 2, 2, 3));
        q0.push_back(mk(2, 0, 1, 7));
        q0.push_back(mk(4, 2, 3, 5));
        q0.push_back(mk(7, 1, 7, 2));
        q1.push_back(mk(3, 0, 1, 6));
        q1.push_back(mk(6, 4, 0, 7));
        q1.push_back(mk(0, 2, 2, 3));
        run_a("t_alt", 6, 8'b0000_0000);

        // Requester 0 alone, then both arrive together.
        push_a(1'b0, mk(2, 0, 0, 1));
        q0.push_back(mk(2, 0, 0, 1));
        run_a("t_arb_pre", 1, 8'b0000_0000);
`ifdef PALU_ISS_RR_EN
        push_a(1'b1, mk(2, 0, 0, 3));
        push_a(1'b0, mk(2, 0, 0, 2));
`else
        push_a(1'b0, mk(2, 0, 0, 2));
        push_a(1'b1, mk(2, 0, 0, 3));
`endif
        q0.push_back(mk(2, 0, 0, 2));
        q1.push_back(mk(2, 0, 0, 3));
        run_a("t_arb", 2, 8'b0000_0000);

        // HZ_STALL=3: three bubbles; locked requester drops req mid-hazard.
        @(negedge clock);
        push_b(1'b0, mk(2, 1, 2, 3));
        push_b(1'b1, mk(3, 3, 0, 4));
        ib.req0 = 1'b1; ib.instr0 = mk(2, 1, 2, 3);
        ib.req1 = 1'b1; ib.instr1 = mk(3, 3, 0, 4);
        @(negedge clock);
        chk("b3_c1_stall", 32'(ib.stall), 32'd0);
        @(negedge clock);
        chk("b3_bub1_stall", 32'(ib.stall), 32'd1);
        chk("b3_bub1_busy", 32'(ib.busy), 32'd1);
        chk("b3_bub1_acks", 32'({ib.ack1, ib.ack0}), 32'd0);
        ib.req0 = 1'b0; ib.instr0 = '0;
        ib.req1 = 1'b0; ib.instr1 = '0;
        @(negedge clock);
        chk("b3_bub2_stall", 32'(ib.stall), 32'd1);
        @(negedge clock);
        chk("b3_bub3_stall", 32'(ib.stall), 32'd1);
        @(negedge clock);
        chk("b3_issue_stall", 32'(ib.stall), 32'd0);
        @(negedge clock);
        chk("b3_after_stall", 32'(ib.stall), 32'd1);
        chk("b3_after_busy", 32'(ib.busy), 32'd0);

        // Reset in the second bubble discards the locked instruction.
        @(negedge clock);
        push_b(1'b0, mk(2, 1, 2, 3));
        push_b(1'b1, mk(3, 3, 0, 4));
        ib.req0 = 1'b1; ib.instr0 = mk(2, 1, 2, 3);
        ib.req1 = 1'b1; ib.instr1 = mk(3, 3, 0, 4);
        @(negedge clock);
        chk("br_c1_stall", 32'(ib.stall), 32'd0);
        @(negedge clock);
        chk("br_bub1_stall", 32'(ib.stall), 32'd1);
        ib.req0 = 1'b0; ib.instr0 = '0;
        @(negedge clock);
        chk("br_bub2_stall", 32'(ib.stall), 32'd1);
        rst_b = 1'b1;
        @(negedge clock);
        chk("br_rst_stall", 32'(ib.stall), 32'd1);
        chk("br_rst_acks", 32'({ib.ack1, ib.ack0}), 32'd0);
        chk("br_rst_fields", 32'({ib.opcode, ib.src1, ib.src2, ib.dest}), 32'd0);
        chk("br_rst_busy", 32'(ib.busy), 32'd0);
        rst_b = 1'b0;
        @(negedge clock);
        chk("br_repres_stall", 32'(ib.stall), 32'd0);
        @(negedge clock);
        chk("br_after_stall", 32'(ib.stall), 32'd1);
        ib.req1 = 1'b0; ib.instr1 = '0;
        @(negedge clock);
        chk("br_idle_busy", 32'(ib.busy), 32'd0);
        chk("br_drained", 32'(sb_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
